// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, winner codes and speed defaults for the pong match sequencer
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_PAUSE,
        ST_POINT,
        ST_OVER
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int PONG_SPEED_MIN = 2;
    localparam int PONG_SPEED_MAX = 5;

    function automatic logic [1:0] winner_code(input logic p1_won, input logic p2_won);
        logic [1:0] code;
        code = WIN_NONE;
        if (p1_won && p2_won) code = WIN_DRAW;
        else if (p1_won)      code = WIN_P1;
        else if (p2_won)      code = WIN_P2;
        return code;
    endfunction

endpackage

// File: rtl/frame_countdown.sv
// rtl/frame_countdown.sv - loadable frame-tick down counter shared by the serve and post-point waits
module frame_countdown (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       frame_tick,
    output logic [7:0] countdown,
    output logic       expire
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 8'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (frame_tick && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    // Not gated by load: the owner reloads on this same pulse when chaining POINT into SERVE.
    assign expire    = frame_tick && (r_count == 8'd1);
    assign countdown = r_count;

endmodule

// File: rtl/pong_match_sequencer.sv
// rtl/pong_match_sequencer.sv - match FSM, scores, ball-speed schedule and mode latch; PONG_SPEEDUP_EN enables speed ramp
module pong_match_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = 5,
    parameter int SCORE_W        = 4,
    parameter int SERVE_FRAMES   = 60,
    parameter int POINT_FRAMES   = 30,
    parameter int SPEEDUP_FRAMES = 600,
    parameter int SPEED_MIN      = PONG_SPEED_MIN,
    parameter int SPEED_MAX      = PONG_SPEED_MAX
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               mode_sel,
    input  logic               point_p1,
    input  logic               point_p2,
    output logic               game_active,
    output logic               ball_reset,
    output logic               multiple_ball_mode,
    output logic [3:0]         ball_speed,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [7:0]         countdown,
    output logic               game_over,
    output logic [1:0]         winner
);

    // A misconfigured ceiling below the serve speed clamps the serve speed down to it.
    localparam logic [3:0] SPEED_BASE = (SPEED_MAX < SPEED_MIN) ? 4'(SPEED_MAX) : 4'(SPEED_MIN);
    localparam logic [3:0] SPEED_CEIL = 4'(SPEED_MAX);

    state_t             r_state, w_next;
    logic               r_active, r_reset_pulse, r_mode, r_over;
    logic [3:0]         r_speed;
    logic [SCORE_W-1:0] r_s1, r_s2;
    logic [1:0]         r_winner;

    logic               w_start, w_point, w_win1, w_win2, w_to_point, w_serve_reentry;
    logic [SCORE_W-1:0] w_s1, w_s2;
    logic               w_load, w_expire;
    logic [7:0]         w_load_val, w_count;

    logic               w_active_n, w_reset_pulse_n, w_mode_n, w_over_n;
    logic [3:0]         w_speed_n;
    logic [SCORE_W-1:0] w_s1_n, w_s2_n;
    logic [1:0]         w_winner_n;

    assign w_start         = start_btn && ((r_state == ST_IDLE) || (r_state == ST_OVER));
    assign w_point         = (r_state == ST_PLAY) && (point_p1 || point_p2);
    assign w_s1            = r_s1 + SCORE_W'(point_p1);
    assign w_s2            = r_s2 + SCORE_W'(point_p2);
    assign w_win1          = (w_s1 >= SCORE_W'(WIN_SCORE));
    assign w_win2          = (w_s2 >= SCORE_W'(WIN_SCORE));
    assign w_to_point      = w_point && !(w_win1 || w_win2);
    assign w_serve_reentry = (r_state == ST_POINT) && w_expire;

    assign w_load     = w_start || w_to_point || w_serve_reentry;
    assign w_load_val = w_point ? 8'(POINT_FRAMES) : 8'(SERVE_FRAMES);

    frame_countdown u_countdown (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (w_load),
        .load_val   (w_load_val),
        .frame_tick (frame_tick),
        .countdown  (w_count),
        .expire     (w_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_active      <= 1'b0;
            r_reset_pulse <= 1'b0;
            r_mode        <= 1'b0;
            r_over        <= 1'b0;
            r_speed       <= SPEED_BASE;
            r_s1          <= '0;
            r_s2          <= '0;
            r_winner      <= WIN_NONE;
        end else begin
            r_state       <= w_next;
            r_active      <= w_active_n;
            r_reset_pulse <= w_reset_pulse_n;
            r_mode        <= w_mode_n;
            r_over        <= w_over_n;
            r_speed       <= w_speed_n;
            r_s1          <= w_s1_n;
            r_s2          <= w_s2_n;
            r_winner      <= w_winner_n;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_OVER: if (w_start) w_next = ST_SERVE;
            ST_SERVE:         if (w_expire) w_next = ST_PLAY;
            ST_PLAY: begin
                // A point in the same cycle as pause takes precedence.
                if (w_point)        w_next = (w_win1 || w_win2) ? ST_OVER : ST_POINT;
                else if (pause_btn) w_next = ST_PAUSE;
            end
            ST_PAUSE:         if (pause_btn) w_next = ST_PLAY;
            ST_POINT:         if (w_expire) w_next = ST_SERVE;
            default:          w_next = ST_IDLE;
        endcase
    end

`ifdef PONG_SPEEDUP_EN
    localparam logic [9:0] STEP_LAST = 10'(SPEEDUP_FRAMES - 1);

    logic [9:0] r_timer, w_timer_n;
    logic       w_step;

    assign w_step = (r_state == ST_PLAY) && frame_tick && (r_timer == STEP_LAST);

    always_comb begin
        w_timer_n = r_timer;
        if (w_start || w_serve_reentry)             w_timer_n = 10'd0;
        else if (w_step)                            w_timer_n = 10'd0;
        else if ((r_state == ST_PLAY) && frame_tick) w_timer_n = r_timer + 10'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_timer <= 10'd0;
        else          r_timer <= w_timer_n;
    end
`else
    logic w_step;
    assign w_step = 1'b0;
`endif

    always_comb begin
        w_active_n      = (w_next == ST_PLAY);
        w_over_n        = (w_next == ST_OVER);
        w_reset_pulse_n = w_start || w_to_point;
        w_mode_n        = w_start ? mode_sel : r_mode;
        w_s1_n          = r_s1;
        w_s2_n          = r_s2;
        w_winner_n      = r_winner;
        w_speed_n       = r_speed;
        if (w_start) begin
            w_s1_n     = '0;
            w_s2_n     = '0;
            w_winner_n = WIN_NONE;
        end else if (w_point) begin
            w_s1_n = w_s1;
            w_s2_n = w_s2;
            if (w_win1 || w_win2) w_winner_n = winner_code(w_win1, w_win2);
        end
        if (w_start || w_to_point)                 w_speed_n = SPEED_BASE;
        else if (w_step && (r_speed < SPEED_CEIL)) w_speed_n = r_speed + 4'd1;
    end

    assign game_active        = r_active;
    assign ball_reset         = r_reset_pulse;
    assign multiple_ball_mode = r_mode;
    assign ball_speed         = r_speed;
    assign score_p1           = r_s1;
    assign score_p2           = r_s2;
    assign countdown          = w_count;
    assign game_over          = r_over;
    assign winner             = r_winner;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// tb/tb_pong_match_sequencer.sv - scoreboard bench for pong_match_sequencer
module tb_pong_match_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
    logic       mode_sel = 1'b0, point_p1 = 1'b0, point_p2 = 1'b0;
    logic       game_active, ball_reset, multiple_ball_mode, game_over;
    logic [3:0] ball_speed, score_p1, score_p2;
    logic [7:0] countdown;
    logic [1:0] winner;

    localparam int SG_GA = 0, SG_BR = 1, SG_MODE = 2, SG_SPD = 3, SG_S1 = 4;
    localparam int SG_S2 = 5, SG_CD = 6, SG_GO = 7, SG_WIN = 8;

`ifdef PONG_SPEEDUP_EN
    localparam int SPD1 = 3, SPD2 = 4, SPD3 = 5, SPD4 = 5;
`else
    localparam int SPD1 = 2, SPD2 = 2, SPD3 = 2, SPD4 = 2;
`endif

    typedef struct {
        string tag;
        int    sig;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pong_match_sequencer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .frame_tick         (frame_tick),
        .start_btn          (start_btn),
        .pause_btn          (pause_btn),
        .mode_sel           (mode_sel),
        .point_p1           (point_p1),
        .point_p2           (point_p2),
        .game_active        (game_active),
        .ball_reset         (ball_reset),
        .multiple_ball_mode (multiple_ball_mode),
        .ball_speed         (ball_speed),
        .score_p1           (score_p1),
        .score_p2           (score_p2),
        .countdown          (countdown),
        .game_over          (game_over),
        .winner             (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    function automatic int observe(input int sig);
        case (sig)
            SG_GA:   return int'(game_active);
            SG_BR:   return int'(ball_reset);
            SG_MODE: return int'(multiple_ball_mode);
            SG_SPD:  return int'(ball_speed);
            SG_S1:   return int'(score_p1);
            SG_S2:   return int'(score_p2);
            SG_CD:   return int'(countdown);
            SG_GO:   return int'(game_over);
            default: return int'(winner);
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sig, input int val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic cyc(input logic ft, input logic st, input logic pb, input logic p1, input logic p2);
        @(negedge clk);
        frame_tick = ft; start_btn = st; pause_btn = pb; point_p1 = p1; point_p2 = p2;
        @(posedge clk);
        #1;
        frame_tick = 1'b0; start_btn = 1'b0; pause_btn = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_reset_values(input string pfx);
        expect_v({pfx, "_ga"},   SG_GA, 0);
        expect_v({pfx, "_br"},   SG_BR, 0);
        expect_v({pfx, "_mode"}, SG_MODE, 0);
        expect_v({pfx, "_spd"},  SG_SPD, 2);
        expect_v({pfx, "_s1"},   SG_S1, 0);
        expect_v({pfx, "_s2"},   SG_S2, 0);
        expect_v({pfx, "_cd"},   SG_CD, 0);
        expect_v({pfx, "_go"},   SG_GO, 0);
        expect_v({pfx, "_win"},  SG_WIN, 0);
        drain();
    endtask

    task automatic start_match(input logic mode);
        mode_sel = mode;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        mode_sel = ~mode;
        expect_v("start_br", SG_BR, 1);
        expect_v("start_cd", SG_CD, 60);
        expect_v("start_mode", SG_MODE, int'(mode));
        expect_v("start_s1", SG_S1, 0);
        expect_v("start_s2", SG_S2, 0);
        expect_v("start_win", SG_WIN, 0);
        expect_v("start_go", SG_GO, 0);
        expect_v("start_ga", SG_GA, 0);
        expect_v("start_spd", SG_SPD, 2);
        drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("start_br_fall", SG_BR, 0);
        expect_v("start_cd_hold", SG_CD, 60);
        expect_v("start_mode_held", SG_MODE, int'(mode));
        drain();
    endtask

    task automatic serve();
        ticks(59);
        expect_v("serve_cd_last", SG_CD, 1);
        expect_v("serve_ga_low", SG_GA, 0);
        drain();
        ticks(1);
        expect_v("serve_ga_rise", SG_GA, 1);
        expect_v("serve_cd_zero", SG_CD, 0);
        expect_v("serve_br_low", SG_BR, 0);
        drain();
    endtask

    task automatic score(input logic p1, input logic p2, input int e1, input int e2, input logic ends);
        cyc(1'b0, 1'b0, 1'b0, p1, p2);
        expect_v("pt_s1", SG_S1, e1);
        expect_v("pt_s2", SG_S2, e2);
        expect_v("pt_ga", SG_GA, 0);
        if (ends) begin
            expect_v("pt_over_go", SG_GO, 1);
            expect_v("pt_over_br", SG_BR, 0);
            drain();
        end else begin
            expect_v("pt_br", SG_BR, 1);
            expect_v("pt_cd", SG_CD, 30);
            expect_v("pt_spd", SG_SPD, 2);
            expect_v("pt_go", SG_GO, 0);
            drain();
            ticks(30);
            expect_v("gap_cd_serve", SG_CD, 60);
            expect_v("gap_br", SG_BR, 0);
            expect_v("gap_ga", SG_GA, 0);
            drain();
            serve();
        end
    endtask

    initial begin
        #12;
        expect_reset_values("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Match 1: P1 wins 5:0 with multi-ball mode latched.
        start_match(1'b1);
        serve();
        for (int k = 1; k <= 4; k++) score(1'b1, 1'b0, k, 0, 1'b0);
        score(1'b1, 1'b0, 5, 0, 1'b1);
        expect_v("m1_winner", SG_WIN, 1);
        drain();

        // Ignored inputs in OVER.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_v("over_hold_s1", SG_S1, 5);
        expect_v("over_hold_go", SG_GO, 1);
        drain();

        // Match 2: reach 4:4 then a simultaneous point gives a draw.
        start_match(1'b0);
        serve();
        for (int k = 1; k <= 4; k++) begin
            score(1'b1, 1'b0, k, k - 1, 1'b0);
            score(1'b0, 1'b1, k, k, 1'b0);
        end
        score(1'b1, 1'b1, 5, 5, 1'b1);
        expect_v("m2_winner", SG_WIN, 3);
        drain();

        // Match 3: pause freezes play and ignores points.
        start_match(1'b1);
        serve();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_v("pause_ga", SG_GA, 0);
        expect_v("pause_br", SG_BR, 0);
        drain();
        ticks(1000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_v("resume_ga", SG_GA, 1);
        expect_v("resume_s1", SG_S1, 0);
        expect_v("resume_s2", SG_S2, 0);
        expect_v("resume_spd", SG_SPD, 2);
        expect_v("resume_cd", SG_CD, 0);
        drain();

        // Speed schedule during play.
        ticks(599);
        expect_v("spd_599", SG_SPD, 2);
        drain();
        ticks(1);
        expect_v("spd_600", SG_SPD, SPD1);
        drain();
        ticks(600);
        expect_v("spd_1200", SG_SPD, SPD2);
        drain();
        ticks(600);
        expect_v("spd_1800", SG_SPD, SPD3);
        drain();
        ticks(600);
        expect_v("spd_2400", SG_SPD, SPD4);
        expect_v("spd_ga", SG_GA, 1);
        drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_v("spd_point_reset", SG_SPD, 2);
        expect_v("spd_point_s1", SG_S1, 1);
        expect_v("spd_point_cd", SG_CD, 30);
        drain();
        ticks(10);
        expect_v("mid_point_cd", SG_CD, 20);
        drain();

        // Asynchronous reset mid-POINT, sampled before any further clock edge.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        expect_reset_values("async_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
